spi_slave_shifter: RTL and testbench

SPI responder (slave) datapath, the counterpart of the SPI master's clock and edge generation.
- Oversamples external sclk, mosi and cs_n in the pclk domain and detects sclk leading and trailing edges per CPOL/CPHA.
- Shifts receive data in from mosi and transmit data out on miso, one DATA_W word per DATA_W sclk cycles.
- Exposes a valid/ready transmit holding register and a one-cycle receive strobe to the APB-side register block.

---
 rtl/spi_pkg.sv | 17 +
 rtl/spi_slave_edge_sync.sv | 57 +++++
 rtl/spi_slave_shifter.sv | 202 ++++++++++++++++++++
 tb/tb_spi_slave_shifter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI responder datapath.
package spi_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  localparam int SPI_DATA_W_DEFAULT      = 8;
  localparam int SPI_SYNC_STAGES_DEFAULT = 2;

  // With cpha=0 the first sclk edge of a bit samples; with cpha=1 the second one does.
  function automatic logic sample_is_leading(input logic cpha);
    return ~cpha;
  endfunction

endpackage

// File: rtl/spi_slave_edge_sync.sv
// Brings sclk, mosi and cs_n into the pclk domain and flags sclk/cs_n transitions.
module spi_slave_edge_sync
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = SPI_SYNC_STAGES_DEFAULT
) (
  input  logic pclk,
  input  logic preset,
  input  logic sclk,
  input  logic mosi,
  input  logic cs_n,
  input  logic cpol,
  output logic sclk_lead,
  output logic sclk_trail,
  output logic mosi_s,
  output logic cs_fall,
  output logic cs_rise,
  output logic cs_n_s
);

  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic [SYNC_STAGES-1:0] csn_sync_q;
  logic                   sclk_hist_q;
  logic                   csn_hist_q;
  logic                   sclk_s;

  // Synchronizer chains plus one history flop per edge-detected signal.
  // sclk resets to its idle level so leaving reset never looks like an edge.
  always_ff @(posedge pclk) begin
    if (preset) begin
      sclk_sync_q <= {SYNC_STAGES{cpol}};
      mosi_sync_q <= '0;
      csn_sync_q  <= '1;
      sclk_hist_q <= cpol;
      csn_hist_q  <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], cs_n};
      sclk_hist_q <= sclk_sync_q[SYNC_STAGES-1];
      csn_hist_q  <= csn_sync_q[SYNC_STAGES-1];
    end
  end

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
  assign cs_n_s = csn_sync_q[SYNC_STAGES-1];

  // Leading edge leaves the idle level, trailing edge returns to it.
  assign sclk_lead  = (sclk_s != sclk_hist_q) && (sclk_s != cpol);
  assign sclk_trail = (sclk_s != sclk_hist_q) && (sclk_s == cpol);

  assign cs_fall = csn_hist_q & ~cs_n_s;
  assign cs_rise = ~csn_hist_q & cs_n_s;

endmodule

// File: rtl/spi_slave_shifter.sv
// SPI responder: frame FSM, bit counter, receive/transmit shifters and
// a single-entry transmit holding register.
module spi_slave_shifter
  import spi_pkg::*;
#(
  parameter int DATA_W      = SPI_DATA_W_DEFAULT,
  parameter int SYNC_STAGES = SPI_SYNC_STAGES_DEFAULT
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  input  logic              sclk,
  input  logic              mosi,
  input  logic              cs_n,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              tx_underrun
);

  localparam int                CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);

  state_e state_q, state_d;

  logic              cpol_q, cpol_d;
  logic              cpha_q, cpha_d;
  logic              lsb_q, lsb_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              hold_full_q, hold_full_d;
  logic              underrun_q, underrun_d;

  logic              sclk_lead, sclk_trail, mosi_s, cs_fall, cs_rise, cs_n_s;
  logic              active, cpol_eff, sample_lead;
  logic              sample_edge, shift_edge, start, abort, load, accept, rx_done;
  logic [DATA_W-1:0] rx_shift_in;

  assign active   = (state_q == ACTIVE);
  // Edge polarity tracks the live cpol while idle and the frame's latched copy once active.
  assign cpol_eff = active ? cpol_q : cpol;

  spi_slave_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync (
    .pclk      (pclk),
    .preset    (preset),
    .sclk      (sclk),
    .mosi      (mosi),
    .cs_n      (cs_n),
    .cpol      (cpol_eff),
    .sclk_lead (sclk_lead),
    .sclk_trail(sclk_trail),
    .mosi_s    (mosi_s),
    .cs_fall   (cs_fall),
    .cs_rise   (cs_rise),
    .cs_n_s    (cs_n_s)
  );

  // Edges only count inside a frame; the cs_n_s gate lets a same-cycle abort win.
  assign sample_lead = sample_is_leading(cpha_q);
  assign sample_edge = active && !cs_n_s && (sample_lead ? sclk_lead : sclk_trail);
  assign shift_edge  = active && !cs_n_s && (sample_lead ? sclk_trail : sclk_lead);
  assign start       = !active && cs_fall;
  assign abort       = active && cs_rise;

  // A shift edge seen with bit_cnt==0 is either the first edge of a word (cpha=1)
  // or the edge right after a word's final sample (cpha=0); cpha=0 also loads at cs_n assertion.
  assign load   = (start && !cpha) || (shift_edge && (bit_cnt_q == '0));
  assign accept = tx_valid && !hold_full_q;

  assign rx_shift_in = lsb_q ? {mosi_s, rx_shift_q[DATA_W-1:1]}
                             : {rx_shift_q[DATA_W-2:0], mosi_s};
  assign rx_done     = sample_edge && (bit_cnt_q == CNT_LAST);

  // Frame state register.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Frame next state: cs_n edges open and close a frame.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cs_fall) state_d = ACTIVE;
      ACTIVE:  if (cs_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next state: mode latch, bit counter, shifters and holding register.
  always_comb begin
    cpol_d      = cpol_q;
    cpha_d      = cpha_q;
    lsb_d       = lsb_q;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    tx_shift_d  = tx_shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    underrun_d  = 1'b0;

    if (start) begin
      cpol_d = cpol;
      cpha_d = cpha;
      lsb_d  = lsb_first;
    end

    if (start || abort) begin
      bit_cnt_d  = '0;
      rx_shift_d = '0;
    end else if (sample_edge) begin
      bit_cnt_d  = (bit_cnt_q == CNT_LAST) ? '0 : bit_cnt_q + CNT_W'(1);
      rx_shift_d = rx_shift_in;
    end

    if (rx_done) begin
      rx_data_d  = rx_shift_in;
      rx_valid_d = 1'b1;
    end

    // A load drains the holding register; a write arriving in the same cycle
    // bypasses it, so the register stays empty in that case.
    if (load) begin
      hold_full_d = 1'b0;
    end else if (accept) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end

    if (abort) begin
      tx_shift_d = '0;
    end else if (load) begin
      if (accept) begin
        tx_shift_d = tx_data;
      end else if (hold_full_q) begin
        tx_shift_d = hold_q;
      end else begin
        tx_shift_d = '0;
        underrun_d = 1'b1;
      end
    end else if (shift_edge) begin
      tx_shift_d = lsb_q ? {1'b0, tx_shift_q[DATA_W-1:1]}
                         : {tx_shift_q[DATA_W-2:0], 1'b0};
    end
  end

  // Datapath registers.
  always_ff @(posedge pclk) begin
    if (preset) begin
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      lsb_q       <= 1'b0;
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      tx_shift_q  <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      cpol_q      <= cpol_d;
      cpha_q      <= cpha_d;
      lsb_q       <= lsb_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      tx_shift_q  <= tx_shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      underrun_q  <= underrun_d;
    end
  end

  assign busy        = active;
  assign miso_oe     = active;
  assign miso        = active ? (lsb_q ? tx_shift_q[0] : tx_shift_q[DATA_W-1]) : 1'b0;
  assign tx_ready    = ~hold_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_underrun = underrun_q;

endmodule

// File: tb/tb_spi_slave_shifter.sv
// Directed bench for spi_slave_shifter: a behavioural SPI master drives
// frames in several modes and the responses are checked against hand values.
module tb_spi_slave_shifter;

  localparam int HALF = 8;

  logic       pclk = 1'b0;
  logic       preset, cpol, cpha, lsb_first, sclk, mosi, cs_n;
  logic       miso, miso_oe, tx_valid, tx_ready, rx_valid, busy, tx_underrun;
  logic [7:0] tx_data, rx_data;
  logic [7:0] got, got2;

  int total = 0;
  int bad = 0;
  int rx_cnt = 0;
  int ur_cnt = 0;
  int rb, ub;

  spi_slave_shifter #(
    .DATA_W(8),
    .SYNC_STAGES(2)
  ) dut (
    .pclk       (pclk),
    .preset     (preset),
    .cpol       (cpol),
    .cpha       (cpha),
    .lsb_first  (lsb_first),
    .sclk       (sclk),
    .mosi       (mosi),
    .cs_n       (cs_n),
    .miso       (miso),
    .miso_oe    (miso_oe),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .busy       (busy),
    .tx_underrun(tx_underrun)
  );

  always #5 pclk = ~pclk;

  // Count one-cycle strobes, sampled on the falling edge.
  always @(negedge pclk) begin
    if (rx_valid === 1'b1) rx_cnt++;
    if (tx_underrun === 1'b1) ur_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge pclk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
    $display("check %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic set_mode(input logic pol, input logic pha, input logic lsb);
    cpol = pol; cpha = pha; lsb_first = lsb; sclk = pol;
    wait_cyc(6);
  endtask

  task automatic start_frame();
    cs_n = 1'b0;
    wait_cyc(6);
  endtask

  task automatic end_frame();
    cs_n = 1'b1;
    wait_cyc(6);
  endtask

  // Write one word into the holding register, bounded wait on tx_ready.
  task automatic write_hold(input logic [7:0] d);
    logic ok;
    ok = 1'b0;
    @(negedge pclk);
    tx_data = d; tx_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      if (tx_ready === 1'b1) begin ok = 1'b1; break; end
      @(negedge pclk);
    end
    @(negedge pclk);
    tx_valid = 1'b0;
    chk("hold_accept", 32'(ok), 32'(1'b1));
  endtask

  // Master side of nbits bit times; miso is captured on the master's sample edge.
  task automatic xfer(input logic [7:0] w, input int nbits, output logic [7:0] rcv);
    rcv = '0;
    for (int i = 0; i < nbits; i++) begin
      int idx;
      idx = lsb_first ? i : 7 - i;
      if (!cpha) begin
        mosi = w[idx];
        wait_cyc(HALF);
        sclk = ~cpol; rcv[idx] = miso;
        wait_cyc(HALF);
        sclk = cpol;
      end else begin
        sclk = ~cpol; mosi = w[idx];
        wait_cyc(HALF);
        sclk = cpol; rcv[idx] = miso;
        wait_cyc(HALF);
      end
    end
    wait_cyc(HALF);
  endtask

  initial begin
    preset = 1'b1; cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0;
    sclk = 1'b0; mosi = 1'b0; cs_n = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
    wait_cyc(5);
    preset = 1'b0;
    wait_cyc(2);
    chk("rst_miso", 32'(miso), 32'(1'b0));
    chk("rst_miso_oe", 32'(miso_oe), 32'(1'b0));
    chk("rst_tx_ready", 32'(tx_ready), 32'(1'b1));
    chk("rst_rx_data", 32'(rx_data), 32'(8'h00));
    chk("rst_rx_valid", 32'(rx_valid), 32'(1'b0));
    chk("rst_busy", 32'(busy), 32'(1'b0));
    chk("rst_underrun", 32'(tx_underrun), 32'(1'b0));

    // Mode 0, holding 0x3C, master sends 0xA5 MSB first.
    write_hold(8'h3C);
    chk("t1_ready_full", 32'(tx_ready), 32'(1'b0));
    start_frame();
    chk("t1_busy", 32'(busy), 32'(1'b1));
    chk("t1_miso_oe", 32'(miso_oe), 32'(1'b1));
    chk("t1_ready_loaded", 32'(tx_ready), 32'(1'b1));
    rb = rx_cnt;
    xfer(8'hA5, 8, got);
    chk("t1_miso_word", 32'(got), 32'(8'h3C));
    chk("t1_rx_data", 32'(rx_data), 32'(8'hA5));
    chk("t1_rx_pulses", 32'(rx_cnt - rb), 32'(1));
    end_frame();
    chk("t1_busy_end", 32'(busy), 32'(1'b0));
    chk("t1_oe_end", 32'(miso_oe), 32'(1'b0));

    // Mode 3, holding 0xC3, master sends 0x5A.
    set_mode(1'b1, 1'b1, 1'b0);
    write_hold(8'hC3);
    start_frame();
    chk("t2_ready_unloaded", 32'(tx_ready), 32'(1'b0));
    chk("t2_miso_pre", 32'(miso), 32'(1'b0));
    rb = rx_cnt;
    xfer(8'h5A, 8, got);
    chk("t2_miso_word", 32'(got), 32'(8'hC3));
    chk("t2_rx_data", 32'(rx_data), 32'(8'h5A));
    chk("t2_rx_pulses", 32'(rx_cnt - rb), 32'(1));
    chk("t2_ready_after", 32'(tx_ready), 32'(1'b1));
    end_frame();

    // Back-to-back words in mode 0; holding kept fed so no load finds it empty.
    set_mode(1'b0, 1'b0, 1'b0);
    write_hold(8'h11);
    rb = rx_cnt; ub = ur_cnt;
    start_frame();
    write_hold(8'h22);
    xfer(8'hF0, 8, got);
    chk("t3_rx_data0", 32'(rx_data), 32'(8'hF0));
    write_hold(8'h33);
    xfer(8'h0F, 8, got2);
    chk("t3_rx_data1", 32'(rx_data), 32'(8'h0F));
    end_frame();
    chk("t3_miso_word0", 32'(got), 32'(8'h11));
    chk("t3_miso_word1", 32'(got2), 32'(8'h22));
    chk("t3_rx_pulses", 32'(rx_cnt - rb), 32'(2));
    chk("t3_underruns", 32'(ur_cnt - ub), 32'(0));

    // Abort after 5 bits of 0xFF, then a clean 0x81 frame.
    rb = rx_cnt;
    start_frame();
    xfer(8'hFF, 5, got);
    end_frame();
    chk("t4_abort_pulses", 32'(rx_cnt - rb), 32'(0));
    chk("t4_abort_rx_data", 32'(rx_data), 32'(8'h0F));
    chk("t4_abort_oe", 32'(miso_oe), 32'(1'b0));
    chk("t4_abort_busy", 32'(busy), 32'(1'b0));
    rb = rx_cnt;
    start_frame();
    xfer(8'h81, 8, got);
    end_frame();
    chk("t4_rx_data", 32'(rx_data), 32'(8'h81));
    chk("t4_rx_pulses", 32'(rx_cnt - rb), 32'(1));

    // Holding empty at cs_n assertion: one underrun, miso all zero.
    rb = rx_cnt; ub = ur_cnt;
    start_frame();
    chk("t5_underrun_start", 32'(ur_cnt - ub), 32'(1));
    write_hold(8'h00);
    xfer(8'h96, 8, got);
    end_frame();
    chk("t5_miso_word", 32'(got), 32'(8'h00));
    chk("t5_rx_data", 32'(rx_data), 32'(8'h96));
    chk("t5_rx_pulses", 32'(rx_cnt - rb), 32'(1));
    chk("t5_underruns", 32'(ur_cnt - ub), 32'(1));

    // Mode 1, LSB first, holding 0x80, master sends 0x01.
    set_mode(1'b0, 1'b1, 1'b1);
    write_hold(8'h80);
    start_frame();
    xfer(8'h01, 8, got);
    end_frame();
    chk("t6_miso_word", 32'(got), 32'(8'h80));
    chk("t6_first_bit", 32'(got[0]), 32'(1'b0));
    chk("t6_last_bit", 32'(got[7]), 32'(1'b1));
    chk("t6_rx_data", 32'(rx_data), 32'(8'h01));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
